fetch_unit: RTL

Instruction-fetch stage that feeds the decode stage. It owns the fetch PC and issues requests to instruction memory over a req/ack handshake that tolerates variable latency. It delivers `pc_id`/`instr_id` through the IF/ID register, with a one-entry skid buffer for decode stalls. It consumes the decode stage's redirect outputs (`jump_branch`, `jump_target`, `jump_reg`, `jr_pc`) and honours the MIPS branch delay slot.

---
 rtl/fetch_unit_if.sv | 11 +
 rtl/fetch_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request channel between the fetch stage and instruction memory.
// req/addr are held stable until ack; rdata is valid only in the ack cycle.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC and feeds IF/ID; an ack in cycle t is visible in ID at t+1.
// Decode stall parks one instruction in a skid and drops imem_req until ID drains.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  input  logic         stall,
  input  logic         jump_branch,
  input  logic         jump_target,
  input  logic         jump_reg,
  input  logic [31:0]  jr_pc,
  output logic [31:0]  pc_id,
  output logic [31:0]  instr_id,
  output logic         instr_valid_id
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic [31:0] redir_tgt;
  logic        redir_pending;
  logic [31:0] pc4;
  logic [31:0] redir_pc;
  logic        id_accept;
  logic        id_free;
  logic        redir;
  logic        take;
  logic        load_id;
  logic        load_skid;
  logic        skid_to_id;
  logic        drop_id;

  assign id_accept      = instr_valid_id & ~stall;
  assign id_free        = ~instr_valid_id | id_accept;
  assign imem.imem_addr = fetch_pc;
  assign pc4            = pc_id + 32'd4;
  assign redir          = id_accept & (jump_reg | jump_target | jump_branch);

  always_comb begin
    redir_pc = pc4 + {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
    if (jump_reg) begin
      redir_pc = jr_pc;
    end else if (jump_target) begin
      redir_pc = {pc4[31:28], instr_id[25:0], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // imem_req is gated by rst directly so an outstanding request is abandoned immediately.
  always_comb begin
    state_nxt     = state;
    imem.imem_req = 1'b0;
    take          = 1'b0;
    load_id       = 1'b0;
    load_skid     = 1'b0;
    skid_to_id    = 1'b0;
    drop_id       = 1'b0;
    case (state)
      FETCH: begin
        imem.imem_req = ~rst;
        if (imem.imem_ack) begin
          take = 1'b1;
          if (id_free) begin
            load_id = 1'b1;
          end else begin
            load_skid = 1'b1;
            state_nxt = HOLD;
          end
        end else if (id_accept) begin
          drop_id = 1'b1;
        end
      end
      HOLD: begin
        if (id_accept) begin
          skid_to_id = 1'b1;
          state_nxt  = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_id          <= RESET_PC;
      instr_id       <= 32'h0;
      instr_valid_id <= 1'b0;
      skid_pc        <= RESET_PC;
      skid_instr     <= 32'h0;
    end else begin
      if (load_id) begin
        pc_id          <= fetch_pc;
        instr_id       <= imem.imem_rdata;
        instr_valid_id <= 1'b1;
      end else if (skid_to_id) begin
        pc_id          <= skid_pc;
        instr_id       <= skid_instr;
        instr_valid_id <= 1'b1;
      end else if (drop_id) begin
        instr_id       <= 32'h0;
        instr_valid_id <= 1'b0;
      end
      if (load_skid) begin
        skid_pc    <= fetch_pc;
        skid_instr <= imem.imem_rdata;
      end
    end
  end

  // The delay slot is either already fetched (HOLD, or acked this cycle) or still in flight;
  // in the latter case the target waits for that ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc      <= RESET_PC;
      redir_pending <= 1'b0;
      redir_tgt     <= RESET_PC;
    end else begin
      if (redir && (take || state == HOLD)) begin
        fetch_pc <= redir_pc;
      end else if (take) begin
        fetch_pc <= redir_pending ? redir_tgt : fetch_pc + 32'd4;
      end
      if (redir && state == FETCH && !take) begin
        redir_pending <= 1'b1;
        redir_tgt     <= redir_pc;
      end else if (take) begin
        redir_pending <= 1'b0;
      end
    end
  end

endmodule
